// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, row debounce, ASCII key output.
// Define KEYPAD_AUTOREPEAT_EN to emit repeat codes while a key stays held.
module keypad_scanner #(
  parameter int SCAN_DIV     = 250,
  parameter int DEBOUNCE_CNT = 5000,
  parameter int REPEAT_CNT   = 125000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [6:0] key_data_out,
  output logic       key_data_ready,
  output logic       key_busy
);

  localparam int DW = $clog2(SCAN_DIV + 1);
  localparam int BW = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DW-1:0] DWELL_LAST  = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] STABLE_LAST = BW'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 1 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_param_check
    $error("keypad_scanner: SCAN_DIV, DEBOUNCE_CNT and REPEAT_CNT must be >= 1");
  end

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    EMIT,
    WAIT_REL
  } state_t;

  state_t          state;
  logic [3:0]      row_meta;
  logic [3:0]      row_sync;
  logic [1:0]      col_idx;
  logic [1:0]      row_idx;
  logic [DW-1:0]   dwell_cnt;
  logic [BW-1:0]   stable_cnt;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CNT + 1);
  localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CNT - 1);
  logic [RW-1:0] rpt_cnt;
`endif

  function automatic logic [3:0] one_cold(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

  function automatic logic [1:0] lowest_low(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  function automatic logic [6:0] key_ascii(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 7'h31;
      4'h1: return 7'h32;
      4'h2: return 7'h33;
      4'h3: return 7'h41;
      4'h4: return 7'h34;
      4'h5: return 7'h35;
      4'h6: return 7'h36;
      4'h7: return 7'h42;
      4'h8: return 7'h37;
      4'h9: return 7'h38;
      4'hA: return 7'h39;
      4'hB: return 7'h43;
      4'hC: return 7'h2A;
      4'hD: return 7'h30;
      4'hE: return 7'h23;
      default: return 7'h44;
    endcase
  endfunction

  // Only the captured row of the held column is watched while debouncing, so other keys cannot interfere.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= SCAN;
      row_meta       <= 4'hF;
      row_sync       <= 4'hF;
      col_idx        <= 2'd0;
      row_idx        <= 2'd0;
      dwell_cnt      <= '0;
      stable_cnt     <= '0;
      col            <= 4'b1110;
      key_data_out   <= 7'h00;
      key_data_ready <= 1'b0;
      key_busy       <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      rpt_cnt        <= '0;
`endif
    end else begin
      row_meta       <= row;
      row_sync       <= row_meta;
      key_data_ready <= 1'b0;
      case (state)
        SCAN: begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rpt_cnt <= '0;
`endif
          if (dwell_cnt == DWELL_LAST) begin
            dwell_cnt <= '0;
            if (&row_sync) begin
              col_idx <= col_idx + 2'd1;
              col     <= one_cold(col_idx + 2'd1);
            end else begin
              row_idx    <= lowest_low(row_sync);
              stable_cnt <= '0;
              key_busy   <= 1'b1;
              state      <= DEBOUNCE;
            end
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        DEBOUNCE: begin
          if (row_sync[row_idx]) begin
            stable_cnt <= '0;
            col_idx    <= col_idx + 2'd1;
            col        <= one_cold(col_idx + 2'd1);
            key_busy   <= 1'b0;
            state      <= SCAN;
          end else if (stable_cnt == STABLE_LAST) begin
            stable_cnt     <= '0;
            key_data_out   <= key_ascii(row_idx, col_idx);
            key_data_ready <= 1'b1;
            state          <= EMIT;
          end else begin
            stable_cnt <= stable_cnt + 1'b1;
          end
        end
        EMIT: begin
          stable_cnt <= '0;
          state      <= WAIT_REL;
`ifdef KEYPAD_AUTOREPEAT_EN
          // The emit cycle already counts toward the first repeat period.
          rpt_cnt <= (row_sync[row_idx] || REPEAT_CNT == 1) ? '0 : RW'(1);
`endif
        end
        WAIT_REL: begin
          if (&row_sync) begin
            if (stable_cnt == STABLE_LAST) begin
              stable_cnt <= '0;
              col_idx    <= col_idx + 2'd1;
              col        <= one_cold(col_idx + 2'd1);
              key_busy   <= 1'b0;
              state      <= SCAN;
            end else begin
              stable_cnt <= stable_cnt + 1'b1;
            end
          end else begin
            stable_cnt <= '0;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          if (row_sync[row_idx]) begin
            rpt_cnt <= '0;
          end else if (rpt_cnt == RPT_LAST) begin
            rpt_cnt        <= '0;
            key_data_ready <= 1'b1;
          end else begin
            rpt_cnt <= rpt_cnt + 1'b1;
          end
`endif
        end
        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 250, meaning clocks each column is driven per scan step (1 ms at 250 kHz).
REQ-002 SHALL have parameter DEBOUNCE_CNT, default 5000, meaning consecutive stable clocks required for press/release acceptance.
REQ-003 SHALL have parameter REPEAT_CNT, default 125000, meaning autorepeat period in clocks (used only under REQ-030).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port row  input  4  keypad rows, active-low (pulled up), asynchronous to clk.
REQ-007 SHALL have port col  output  4  keypad columns, active-low one-hot drive.
REQ-008 SHALL have port key_data_out  output  7  ASCII code of accepted key, held until next accept.
REQ-009 SHALL have port key_data_ready  output  1  one-clk pulse, high in the cycle key_data_out first holds the new code.
REQ-010 SHALL have port key_busy  output  1  high in DEBOUNCE, EMIT and WAIT_REL states.

Function
REQ-011 SHALL pass row through a 2-flop synchronizer; all decisions use the second flop (2-clk input latency).
REQ-012 SHALL implement states SCAN, DEBOUNCE, EMIT, WAIT_REL.
REQ-013 SCAN: SHALL drive col low on column index c (0..3), hold for SCAN_DIV clocks, sample synced row in the last dwell cycle.
REQ-014 SCAN: all rows high at sample -> c increments, wrapping 3->0; else capture c and lowest-numbered low row r, go DEBOUNCE.
REQ-015 DEBOUNCE: SHALL keep column c driven; counter increments each clk row r stays low, reaching DEBOUNCE_CNT -> EMIT.
REQ-016 DEBOUNCE: row r high in any cycle -> SCAN with c+1 (wrapping), no output.
REQ-017 EMIT: exactly one cycle; key_data_out loads map[r*4+c], key_data_ready=1; next state WAIT_REL.
REQ-018 Map rows 0..3 x cols 0..3: "123A", "456B", "789C", "*0#D" (7-bit ASCII, e.g. '1'=7'h31, '#'=7'h23, 'D'=7'h44).
REQ-019 WAIT_REL: SHALL keep column c driven; release counter increments each clk all rows high, clears on any low row; reaching DEBOUNCE_CNT -> SCAN with c+1.
REQ-020 Additional keys pressed during DEBOUNCE/WAIT_REL SHALL be ignored (no rollover); only row r of column c is tracked in DEBOUNCE.
REQ-021 Counters SHALL be $clog2(param+1) bits wide, saturating never needed; compare by equality to param-1 terminal value.
REQ-022 key_data_ready SHALL never be high two consecutive cycles.
REQ-023 Parameter value 1 for SCAN_DIV/DEBOUNCE_CNT SHALL be legal (single-cycle dwell/accept).

Reset
REQ-024 rst low at a clock edge SHALL force state SCAN, c=0, all counters 0, synchronizer flops 4'hF.
REQ-025 During and after reset: col=4'b1110, key_data_out=7'h00, key_data_ready=0, key_busy=0.
REQ-026 Reset mid-DEBOUNCE/WAIT_REL SHALL abort without emitting; a key still held after reset is re-detected and re-debounced normally.
REQ-027 No output SHALL change asynchronously to clk.

Configuration
REQ-028 Macro KEYPAD_AUTOREPEAT_EN SHALL select autorepeat.
REQ-029 Without the macro: WAIT_REL never emits; one press yields exactly one key_data_ready pulse.
REQ-030 With the macro: in WAIT_REL, a repeat counter counts clocks while row r is low; at REPEAT_CNT, SHALL pulse key_data_ready with same code and restart count; counter clears whenever row r is high.
REQ-031 REPEAT_CNT parameter SHALL exist in both builds; unused logic absent without the macro.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=40)
REQ-032 Reset: rst=0 for 3 clks, rows 4'hF -> col=4'b1110, key_data_out=0, key_data_ready=0 throughout; col steps 1101 after 4 clks from rst release.
REQ-033 Clean press row1/col2 held 100 clks then released -> exactly one pulse, key_data_out=7'h36 ('6'); key_busy falls 8 clks after synced release.
REQ-034 Bounce: row0/col0 low 5 clks, high 1, low 30 -> no pulse during first 5; one pulse with 7'h31 after the stable 8-clk window.
REQ-035 Reset asserted in DEBOUNCE cycle 4 -> no pulse; outputs per REQ-025; key kept held -> one pulse after full re-debounce.
REQ-036 Two keys (row3/col3 then row0/col3 while held) -> single pulse 7'h44; second key ignored until release.
REQ-037 With KEYPAD_AUTOREPEAT_EN, row2/col1 ('8'=7'h38) held 150 clks -> initial pulse plus 3 repeats, 40 clks apart; without macro -> 1 pulse.
